seq_run_ctrl: RTL and testbench
===============================

Name: seq_run_ctrl

Overview:
- Run controller for the five-step sequencer (steps FIRST→SECOND→THIRD→FOURTH→FIFTH). It drives the sequencer's pause, restart and goto_third inputs and watches its terminal flag.
- Executes a programmed number of passes. Pass 1 is FIRST..FIFTH; each later pass loops FIFTH→THIRD→FOURTH→FIFTH.
- Supports free-run and single-step modes, plus abort.
- Sits between the host/test logic and the sequencer; the sequencer shares clk and rst.

Parameters:
- LOOP_W, 4, width of pass-count request and pass counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request a run; sampled in IDLE only.
- loop_count  input  LOOP_W  number of passes N, latched on accepted start.
- step_mode  input  1  1 = single-step; sequencer advances only on step.
- step  input  1  single-cycle advance request, meaningful in RUN with step_mode=1.
- abort  input  1  terminate the run immediately.
- seq_terminal  input  1  from sequencer; high while it is in FIFTH.
- seq_pause  output  1  to sequencer pause.
- seq_restart  output  1  to sequencer restart.
- seq_goto_third  output  1  to sequencer goto_third.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when all N passes complete.
- aborted  output  1  one-cycle pulse after an abort.
- pass_cnt  output  LOOP_W  completed passes in the current or last run.

Behaviour:
- Sequencer contract:
  - restart=1 forces FIRST next cycle.
  - pause=1 holds FIRST..FOURTH.
  - FIFTH ignores pause: it always leaves next cycle, going to THIRD if goto_third=1, else FIRST.
- States: IDLE, RUN, DONE. Reset (sync, rst=1 at a clk edge) → IDLE, pass_cnt=0, done=0, aborted=0, N register=0.
- Outputs:
  - seq_restart = (state!=RUN) | abort.
  - seq_pause = RUN & step_mode & ~step.
  - seq_goto_third = RUN & seq_terminal & ~abort & (pass_cnt+1 < N).
  - busy = (state==RUN).
  - done and aborted are registered pulses.
- IDLE:
  - start=1 & abort=0 & loop_count!=0 → latch N, clear pass_cnt, go RUN.
  - start=1 with loop_count=0 → no run, pass_cnt cleared, done pulses next cycle, stay IDLE.
  - start & abort in the same cycle → ignored.
- RUN:
  - Each cycle with seq_terminal=1 (and no abort) → pass_cnt += 1.
  - If the new pass_cnt equals N → go DONE; otherwise stay RUN (sequencer loops to THIRD).
- DONE: done=1 for exactly one cycle, seq_restart=1, then IDLE.
- Abort in RUN:
  - seq_restart=1 combinationally that cycle; next cycle state=IDLE and aborted=1 for one cycle.
  - pass_cnt holds its value (the terminal in the abort cycle is not counted).
  - Abort outside RUN has no effect.
- start while busy or in DONE → ignored. step outside RUN or with step_mode=0 → no effect.
- Single-step: each step pulse advances the sequencer one position. At FIFTH the sequencer leaves without a step; the controller still counts and decides that pass normally.
- step_mode may change mid-run and takes effect the same cycle.
- pass_cnt arithmetic is LOOP_W bits; N ≤ 2^LOOP_W−1, so the counter never wraps inside a run.
- Free-run timing, start accepted at edge t (state RUN from t):
  - Sequencer in FIRST at t, FIFTH at t+4.
  - Each additional pass adds 3 cycles.
  - Final terminal at t+4+3(N−1); done high the following cycle.
- rst mid-run → IDLE immediately, no done/aborted pulse.

Test Plan:
- Reset, then start with loop_count=1, free-run → seq_terminal at t+4, goto_third=0, done pulse at t+5, pass_cnt=1, busy low at t+5.
- loop_count=3 → goto_third high at the first two terminals (t+4, t+7), low at t+10; done at t+11; pass_cnt=3.
- step_mode=1, loop_count=1, step pulses every 4th cycle → sequencer advances only on steps FIRST..FOURTH, FIFTH exits unpaused; done once, pass_cnt=1.
- loop_count=2, abort asserted the same cycle as the first terminal → seq_restart=1 that cycle, goto_third=0, aborted pulse next cycle, pass_cnt=0, no done.
- start with loop_count=0 → no RUN, done pulse next cycle; start while busy → ignored (N unchanged, no restart).
- rst asserted mid-run with loop_count=5 → next cycle IDLE, pass_cnt=0, seq_restart=1, no pulses.

Source files
------------

// File: rtl/seq_run_ctrl.sv
// ---------------------------------------------------------------------------
// seq_run_ctrl
//
// Run controller for the five-step sequencer (FIRST..FIFTH). It starts a run
// of N passes, keeps the sequencer looping FIFTH->THIRD between passes, and
// supports single-step operation and abort.
//
// Ports:
//   clk, rst        system clock (rising edge), synchronous active-high reset
//   start           run request, sampled in IDLE only
//   loop_count      number of passes N, latched when a start is accepted
//   step_mode       1 = sequencer advances only on step pulses
//   step            single-cycle advance request (RUN with step_mode=1)
//   abort           terminate the current run immediately
//   seq_terminal    from sequencer, high while it sits in FIFTH
//   seq_pause       to sequencer, holds FIRST..FOURTH
//   seq_restart     to sequencer, forces FIRST next cycle
//   seq_goto_third  to sequencer, FIFTH exits to THIRD instead of FIRST
//   busy            high while a run is in progress
//   done            one-cycle pulse when all N passes are complete
//   aborted         one-cycle pulse after an accepted abort
//   pass_cnt        completed passes in the current or last run
//
// Handshake: start is a level request consumed in the one IDLE cycle it is
// seen; step is a single-cycle strobe; done/aborted are single-cycle strobes
// with no acknowledge. The FSM state is held in 'state' (enum state_t).
// ---------------------------------------------------------------------------
module seq_run_ctrl #(
    parameter int LOOP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LOOP_W-1:0] loop_count,
    input  logic              step_mode,
    input  logic              step,
    input  logic              abort,
    input  logic              seq_terminal,
    output logic              seq_pause,
    output logic              seq_restart,
    output logic              seq_goto_third,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [LOOP_W-1:0] pass_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state;
    logic [LOOP_W-1:0] n_reg;      // requested pass count of the active run
    logic [LOOP_W-1:0] pass_next;  // pass count after the current terminal
    logic              in_run;

    assign in_run    = (state == ST_RUN);
    assign pass_next = pass_cnt + LOOP_W'(1);

    // Sequencer controls are combinational so that abort and step act in
    // the same cycle they are presented.
    assign busy           = in_run;
    assign seq_restart    = !in_run || abort;
    assign seq_pause      = in_run && step_mode && !step;
    // Loop back to THIRD only if another pass remains after this terminal.
    // N never exceeds 2^LOOP_W-1, so pass_next cannot wrap within a run.
    assign seq_goto_third = in_run && seq_terminal && !abort && (pass_next < n_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            n_reg    <= '0;
            pass_cnt <= '0;
            done     <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // start together with abort is dropped entirely
                    if (start && !abort) begin
                        pass_cnt <= '0;
                        if (loop_count != '0) begin
                            n_reg <= loop_count;
                            state <= ST_RUN;
                        end else begin
                            // empty run: report completion without running
                            done <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        // terminal seen in the abort cycle is not counted
                        state   <= ST_IDLE;
                        aborted <= 1'b1;
                    end else if (seq_terminal) begin
                        pass_cnt <= pass_next;
                        if (pass_next == n_reg) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq_run_ctrl
//
// Bench for seq_run_ctrl. A small sequencer model closes the loop around the
// controller. Each run is planned up front from per-cycle stimulus tables; a
// reference walk over the sequencer position (0=FIRST..4=FIFTH) predicts the
// ending pulse, its cycle, the final pass count, the number of loop-backs
// and the number of in-run restarts, and pushes that record to exp_q. A
// separate monitor pops a record whenever done or aborted is seen.
// ---------------------------------------------------------------------------
module tb_seq_run_ctrl;

    localparam int LOOP_W = 4;
    localparam int CAP    = 150;
    // record: [26] aborted, [25:22] pass_cnt, [21:18] goto count,
    //         [17:16] in-run restarts, [15:0] cycle of the pulse
    localparam int EW     = 27;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [LOOP_W-1:0] loop_count;
    logic              step_mode;
    logic              step;
    logic              abort;
    logic              seq_terminal;
    logic              seq_pause;
    logic              seq_restart;
    logic              seq_goto_third;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [LOOP_W-1:0] pass_cnt;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int seq_pos = 0;

    logic [EW-1:0] exp_q[$];

    seq_run_ctrl #(.LOOP_W(LOOP_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .loop_count     (loop_count),
        .step_mode      (step_mode),
        .step           (step),
        .abort          (abort),
        .seq_terminal   (seq_terminal),
        .seq_pause      (seq_pause),
        .seq_restart    (seq_restart),
        .seq_goto_third (seq_goto_third),
        .busy           (busy),
        .done           (done),
        .aborted        (aborted),
        .pass_cnt       (pass_cnt)
    );

    // ---------------- clock / reset-related environment ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sequencer model: restart wins, FIFTH always exits, pause holds others.
    always @(posedge clk) begin
        if (rst || seq_restart)  seq_pos <= 0;
        else if (seq_pos == 4)   seq_pos <= seq_goto_third ? 2 : 0;
        else if (!seq_pause)     seq_pos <= seq_pos + 1;
    end
    assign seq_terminal = (seq_pos == 4);

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [EW-1:0] pack(input bit is_ab, input int pc, input int gt,
                                           input int rr, input int c);
        return {is_ab, 4'(pc), 4'(gt), 2'(rr), 16'(c)};
    endfunction

    task automatic drive_idle();
        start      = 1'b0;
        loop_count = '0;
        step_mode  = 1'b0;
        step       = 1'b0;
        abort      = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    // mode 0: free-run, 1: step pulse every 4th cycle, 2: random step/abort.
    // abort_off >= 0 forces an abort at that cycle offset from the start.
    task automatic do_run(input int n, input int mode, input int abort_off);
        bit sm[CAP];
        bit st[CAP];
        bit ab[CAP];
        bit sb[CAP];
        int t;
        int pos;
        int passes;
        int end_i;
        bit is_ab;
        t = cyc + 1;
        for (int i = 0; i < CAP; i++) begin
            case (mode)
                0: begin sm[i] = 1'b0; st[i] = 1'($urandom_range(0, 1)); ab[i] = 1'b0; end
                1: begin sm[i] = 1'b1; st[i] = ((i % 4) == 3); ab[i] = 1'b0; end
                default: begin
                    sm[i] = ($urandom_range(0, 2) != 0);
                    st[i] = 1'($urandom_range(0, 1));
                    ab[i] = ($urandom_range(0, 60) == 0);
                end
            endcase
            sb[i] = ($urandom_range(0, 5) == 0);
        end
        if (abort_off >= 0) ab[abort_off] = 1'b1;
        ab[CAP-1] = 1'b1;  // every run is guaranteed to end

        // reference walk over sequencer positions
        end_i = -1;
        is_ab = 1'b0;
        if (n == 0) begin
            exp_q.push_back(pack(1'b0, 0, 0, 0, t));
        end else begin
            pos    = 0;
            passes = 0;
            for (int i = 0; i < CAP; i++) begin
                if (ab[i]) begin
                    exp_q.push_back(pack(1'b1, passes, passes, 1, t + i + 1));
                    end_i = i;
                    is_ab = 1'b1;
                    break;
                end
                if (pos == 4) begin
                    passes++;
                    if (passes == n) begin
                        exp_q.push_back(pack(1'b0, n, n - 1, 0, t + i + 1));
                        end_i = i;
                        break;
                    end
                    pos = 2;
                end else if (!sm[i] || st[i]) begin
                    pos++;
                end
            end
        end

        start      = 1'b1;
        loop_count = LOOP_W'(n);
        @(negedge clk);  // now in cycle t
        for (int i = 0; i <= end_i; i++) begin
            start      = sb[i];  // starts while busy must be ignored
            loop_count = LOOP_W'($urandom_range(0, 15));
            step_mode  = sm[i];
            step       = st[i];
            abort      = ab[i];
            @(negedge clk);
        end
        drive_idle();
        if (n != 0 && !is_ab) begin
            // this cycle is DONE: a start here must be ignored
            start      = 1'($urandom_range(0, 1));
            loop_count = LOOP_W'($urandom_range(1, 15));
            @(negedge clk);
            drive_idle();
        end
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_pulse: %0d outstanding events, expected 0 (cycle %0d)",
                     exp_q.size(), cyc);
            exp_q.delete();
        end
    endtask

    task automatic start_with_abort();
        start      = 1'b1;
        abort      = 1'b1;
        loop_count = LOOP_W'($urandom_range(1, 15));
        @(negedge clk);
        drive_idle();
        repeat (2) @(negedge clk);
        chk("start_abort_busy", int'(busy), 0);
    endtask

    task automatic idle_gap(input int k);
        for (int i = 0; i < k; i++) begin
            abort      = 1'($urandom_range(0, 1));  // abort outside RUN: no effect
            step       = 1'($urandom_range(0, 1));
            step_mode  = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        drive_idle();
    endtask

    task automatic reset_mid_run();
        start      = 1'b1;
        loop_count = LOOP_W'(5);
        @(negedge clk);  // cycle t
        drive_idle();
        repeat (6) @(negedge clk);  // cycle t+6, one terminal seen at t+4
        chk("rst_pre_busy", int'(busy), 1);
        chk("rst_pre_pass_cnt", int'(pass_cnt), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_pass_cnt", int'(pass_cnt), 0);
        chk("rst_mid_restart", int'(seq_restart), 1);
        chk("rst_mid_done", int'(done), 0);
        chk("rst_mid_aborted", int'(aborted), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin : monitor
        int gt_cnt;
        int rr_cnt;
        logic [EW-1:0] e;
        gt_cnt = 0;
        rr_cnt = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                gt_cnt = 0;
                rr_cnt = 0;
            end else begin
                if (busy && seq_goto_third) gt_cnt++;
                if (busy && seq_restart)    rr_cnt++;
                if (done || aborted) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pulse: done=%0d aborted=%0d, expected none (cycle %0d)",
                                 done, aborted, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pulse_aborted", int'(aborted), int'(e[26]));
                        chk("pulse_done", int'(done), int'(!e[26]));
                        chk("pulse_cycle", cyc, int'(e[15:0]));
                        chk("pass_cnt", int'(pass_cnt), int'(e[25:22]));
                        chk("goto_third_count", gt_cnt, int'(e[21:18]));
                        chk("restart_in_run", rr_cnt, int'(e[17:16]));
                        chk("busy_at_pulse", int'(busy), 0);
                        chk("restart_at_pulse", int'(seq_restart), 1);
                    end
                    gt_cnt = 0;
                    rr_cnt = 0;
                end
            end
        end
    end

    // ---------------- main sequence and final report ----------------
    initial begin
        rst = 1'b1;
        drive_idle();
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_aborted", int'(aborted), 0);
        chk("reset_pass_cnt", int'(pass_cnt), 0);
        chk("reset_restart", int'(seq_restart), 1);
        chk("reset_pause", int'(seq_pause), 0);
        chk("reset_goto_third", int'(seq_goto_third), 0);
        rst = 1'b0;
        @(negedge clk);

        do_run(1, 0, -1);  idle_gap(3);
        do_run(3, 0, -1);  idle_gap(3);
        do_run(1, 1, -1);  idle_gap(3);
        do_run(2, 0, 4);   idle_gap(3);   // abort on the first terminal
        do_run(0, 0, -1);  idle_gap(2);
        start_with_abort(); idle_gap(2);
        do_run(15, 0, -1); idle_gap(2);   // largest pass count
        reset_mid_run();

        repeat (40) begin
            if ($urandom_range(0, 9) == 0) start_with_abort();
            else do_run($urandom_range(0, 8), 2, -1);
            idle_gap($urandom_range(1, 4));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
